// File: rtl/kernel_conv3x3.sv
// Streaming 3x3 neighbourhood filter (Sobel / Gaussian / Laplacian / passthrough)
// over one raster-order WIDTH x HEIGHT frame per start, with ready/valid on both sides.
//
//   state | meaning
//   IDLE  | waiting for start, all handshakes low
//   FILL  | priming line buffers and window, no outputs yet (first W+1 shifts)
//   RUN   | every accepted pixel shifts the window and produces one output
//   FLUSH | all inputs taken; zero columns are pushed to drain the last W+1 outputs
//   DONE  | one-cycle frame_fim pulse, then back to IDLE
module kernel_conv3x3 #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            modo,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_in_valid,
  output logic                  ler_pixel,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_pronto,
  input  logic                  saida_pronta,
  output logic                  ocupado,
  output logic                  frame_fim
);
  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int SHIFTS = TOTAL + WIDTH + 1;
  localparam int CW     = $clog2(SHIFTS + 1);
  localparam int PW     = $clog2(WIDTH);
  localparam int RW     = $clog2(HEIGHT);
  localparam int AW     = DATA_WIDTH + 6;

  localparam logic [CW-1:0] TOTAL_C    = CW'(TOTAL);
  localparam logic [CW-1:0] TOTAL_M1   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SHIFTS_C   = CW'(SHIFTS);
  localparam logic [CW-1:0] PROD_C     = CW'(WIDTH + 1);
  localparam logic [CW-1:0] FILL_LAST  = CW'(WIDTH);
  localparam logic [PW-1:0] COL_LAST   = PW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic signed [AW-1:0] MAX_S = AW'((1 << DATA_WIDTH) - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]            mode_q;
  logic [CW-1:0]         in_cnt, sh_cnt, tx_cnt;
  logic [RW-1:0]         row;
  logic [PW-1:0]         col, ptr;
  logic [DATA_WIDTH-1:0] lb0 [WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [WIDTH];
  // Only the two newest window columns are stored; the third is the incoming column.
  logic [DATA_WIDTH-1:0] win_a [3];
  logic [DATA_WIDTH-1:0] win_b [3];
  logic [DATA_WIDTH-1:0] col_new [3];

  logic producing, out_free, in_xfer, out_xfer, shift_en, load, border;
  logic [DATA_WIDTH-1:0] filt;

  assign col_new[0] = lb1[ptr];
  assign col_new[1] = lb0[ptr];
  assign col_new[2] = (state == FLUSH) ? '0 : pixel_in;

  assign producing = (sh_cnt >= PROD_C);
  assign out_free  = !pixel_pronto || saida_pronta;
  assign ler_pixel = ((state == FILL) || (state == RUN)) && (in_cnt < TOTAL_C) &&
                     (out_free || !producing);
  assign in_xfer   = ler_pixel && pixel_in_valid;
  assign out_xfer  = pixel_pronto && saida_pronta;
  assign shift_en  = (in_xfer || ((state == FLUSH) && (sh_cnt < SHIFTS_C))) &&
                     (!producing || out_free);
  assign load      = shift_en && producing;
  assign border    = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign ocupado   = (state != IDLE);
  assign frame_fim = (state == DONE);

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [AW-1:0] v);
    if (v > MAX_S) return '1;
    return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [AW-1:0] absv(input logic signed [AW-1:0] v);
    return v[AW-1] ? -v : v;
  endfunction

  // Filter evaluated on the window as it looks after the current shift.
  always_comb begin
    logic signed [AW-1:0] p [3][3];
    logic signed [AW-1:0] gx, gy, gs, lp;
    for (int r = 0; r < 3; r++) begin
      p[r][0] = {{(AW-DATA_WIDTH){1'b0}}, win_a[r]};
      p[r][1] = {{(AW-DATA_WIDTH){1'b0}}, win_b[r]};
      p[r][2] = {{(AW-DATA_WIDTH){1'b0}}, col_new[r]};
    end
    gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    gs = p[0][0] + (p[0][1] <<< 1) + p[0][2] + (p[1][0] <<< 1) + (p[1][1] <<< 2) +
         (p[1][2] <<< 1) + p[2][0] + (p[2][1] <<< 1) + p[2][2];
    lp = (p[1][1] <<< 2) - p[0][1] - p[2][1] - p[1][0] - p[1][2];
    filt = '0;
    if (border) begin
      if (mode_q == 2'd3) filt = win_b[1];
    end else begin
      case (mode_q)
        2'd0:    filt = sat(absv(gx) + absv(gy));
        2'd1:    filt = sat(gs >>> 4);
        2'd2:    filt = sat(absv(lp));
        default: filt = win_b[1];
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (shift_en && (sh_cnt == FILL_LAST)) state_nxt = RUN;
      RUN:     if (in_xfer && (in_cnt == TOTAL_M1)) state_nxt = FLUSH;
      FLUSH:   if (out_xfer && (tx_cnt == TOTAL_M1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, mode latch and the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q       <= '0;
      in_cnt       <= '0;
      sh_cnt       <= '0;
      tx_cnt       <= '0;
      row          <= '0;
      col          <= '0;
      ptr          <= '0;
      pixel_out    <= '0;
      pixel_pronto <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        mode_q <= modo;
        in_cnt <= '0;
        sh_cnt <= '0;
        tx_cnt <= '0;
        row    <= '0;
        col    <= '0;
        ptr    <= '0;
      end else begin
        if (in_xfer)  in_cnt <= in_cnt + 1'b1;
        if (out_xfer) tx_cnt <= tx_cnt + 1'b1;
        if (shift_en) begin
          sh_cnt <= sh_cnt + 1'b1;
          ptr    <= (ptr == COL_LAST) ? '0 : ptr + 1'b1;
        end
        if (load) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
      if (load) begin
        pixel_out    <= filt;
        pixel_pronto <= 1'b1;
      end else if (out_xfer) begin
        pixel_pronto <= 1'b0;
      end
    end
  end

  // Line buffers and window shift; contents need no reset.
  always_ff @(posedge clock) begin
    if (shift_en) begin
      lb1[ptr] <= lb0[ptr];
      lb0[ptr] <= col_new[2];
      for (int r = 0; r < 3; r++) begin
        win_a[r] <= win_b[r];
        win_b[r] <= col_new[r];
      end
    end
  end
endmodule

// File: tb/tb_kernel_conv3x3.sv
// Directed bench for kernel_conv3x3 on an 8x6 frame.
module tb_kernel_conv3x3;
  localparam int W = 8;
  localparam int H = 6;
  localparam int TOTAL = W * H;

  logic       clock, reset, start, pixel_in_valid, saida_pronta;
  logic [1:0] modo;
  logic [7:0] pixel_in, pixel_out;
  logic       ler_pixel, pixel_pronto, ocupado, frame_fim;

  logic [7:0] img   [TOTAL];
  logic [7:0] exp_v [TOTAL];
  logic [7:0] got   [TOTAL];

  int n_cmp = 0;
  int n_fail = 0;

  kernel_conv3x3 #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .modo(modo),
    .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid), .ler_pixel(ler_pixel),
    .pixel_out(pixel_out), .pixel_pronto(pixel_pronto), .saida_pronta(saida_pronta),
    .ocupado(ocupado), .frame_fim(frame_fim)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit is_border(input int r, input int c);
    return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
  endfunction

  task automatic run_frame(input string name, input logic [1:0] m, input bit bubbles,
                           input bit stall, input bit pokes);
    int idx, nout, fim_cnt, stall_cnt, bad_stall, c_in9, c_pr, c_last, c_fim, tail;
    logic [7:0] held;
    bit done, stalled;
    idx = 0; nout = 0; fim_cnt = 0; stall_cnt = 0; bad_stall = 0;
    c_in9 = -1; c_pr = -1; c_last = -1; c_fim = -1; tail = 0; done = 0; held = '0;
    @(negedge clock);
    modo = m; start = 1'b1; pixel_in_valid = 1'b0; saida_pronta = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clock);
      modo = ~m;
      start = pokes && ocupado && (cyc % 5 == 2);
      pixel_in_valid = bubbles ? (cyc % 3 != 2) : 1'b1;
      pixel_in = (idx < TOTAL) ? img[idx] : 8'hEE;
      stalled = 1'b0;
      if (stall && nout == 10 && pixel_pronto && stall_cnt < 20) begin
        saida_pronta = 1'b0;
        if (stall_cnt == 0) held = pixel_out;
        stall_cnt++;
        stalled = 1'b1;
      end else if (stall && stall_cnt >= 20) begin
        saida_pronta = 1'($urandom_range(0, 1));
      end else begin
        saida_pronta = 1'b1;
      end
      #1;
      if (stalled && (pixel_out !== held || ler_pixel !== 1'b0 || pixel_pronto !== 1'b1))
        bad_stall++;
      if (ler_pixel && pixel_in_valid) begin
        if (idx == 9) c_in9 = cyc;
        idx++;
      end
      if (pixel_pronto && c_pr < 0) c_pr = cyc;
      if (pixel_pronto && saida_pronta) begin
        if (nout < TOTAL) got[nout] = pixel_out;
        nout++;
        c_last = cyc;
      end
      if (frame_fim) begin
        fim_cnt++;
        c_fim = cyc;
      end
      if (c_fim >= 0) begin
        tail++;
        if (tail > 3) done = 1'b1;
      end
    end
    start = 1'b0; pixel_in_valid = 1'b0; saida_pronta = 1'b1;
    for (int i = 0; i < TOTAL; i++)
      if (i < nout) check($sformatf("%s_px%0d", name, i), got[i], exp_v[i]);
    check({name, "_outputs"}, nout, TOTAL);
    check({name, "_inputs"}, idx, TOTAL);
    check({name, "_fim_count"}, fim_cnt, 1);
    check({name, "_fim_timing"}, c_fim, c_last + 1);
    check({name, "_first_pronto"}, c_pr, c_in9 + 1);
    check({name, "_idle_after"}, ocupado, 0);
    if (stall) begin
      check({name, "_stall_len"}, stall_cnt, 20);
      check({name, "_stall_hold"}, bad_stall, 0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; modo = 2'd0; pixel_in = '0;
    pixel_in_valid = 1'b0; saida_pronta = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_pronto", pixel_pronto, 0);
    check("rst_out", pixel_out, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_ler", ler_pixel, 0);
    check("rst_fim", frame_fim, 0);
    reset = 1'b1;

    // Flat 100, Sobel: everything 0.
    for (int i = 0; i < TOTAL; i++) begin img[i] = 8'd100; exp_v[i] = 8'd0; end
    run_frame("flat_sobel", 2'd0, 1'b0, 1'b0, 1'b0);

    // Flat 100, Gaussian: interior 100, border 0.
    for (int i = 0; i < TOTAL; i++) exp_v[i] = is_border(i / W, i % W) ? 8'd0 : 8'd100;
    run_frame("flat_gauss", 2'd1, 1'b0, 1'b0, 1'b0);

    // Vertical step, Sobel, with a stall at output 10: interior cols 3,4 saturate.
    for (int i = 0; i < TOTAL; i++) begin
      img[i] = (i % W >= 4) ? 8'd200 : 8'd0;
      exp_v[i] = (!is_border(i / W, i % W) && (i % W == 3 || i % W == 4)) ? 8'd255 : 8'd0;
    end
    run_frame("step_sobel", 2'd0, 1'b0, 1'b1, 1'b0);

    // Impulse 50 at (2,3), Laplacian, input bubbles and ignored start pulses.
    for (int i = 0; i < TOTAL; i++) begin img[i] = 8'd0; exp_v[i] = 8'd0; end
    img[2*W+3] = 8'd50;
    exp_v[2*W+3] = 8'd200;
    exp_v[1*W+3] = 8'd50; exp_v[3*W+3] = 8'd50;
    exp_v[2*W+2] = 8'd50; exp_v[2*W+4] = 8'd50;
    run_frame("imp_lap", 2'd2, 1'b1, 1'b0, 1'b1);

    // Impulse 160 at (2,3), Gaussian, input bubbles.
    for (int i = 0; i < TOTAL; i++) begin img[i] = 8'd0; exp_v[i] = 8'd0; end
    img[2*W+3] = 8'd160;
    exp_v[2*W+3] = 8'd40;
    exp_v[1*W+3] = 8'd20; exp_v[3*W+3] = 8'd20;
    exp_v[2*W+2] = 8'd20; exp_v[2*W+4] = 8'd20;
    exp_v[1*W+2] = 8'd10; exp_v[1*W+4] = 8'd10;
    exp_v[3*W+2] = 8'd10; exp_v[3*W+4] = 8'd10;
    run_frame("imp_gauss", 2'd1, 1'b1, 1'b0, 1'b0);

    // Abort a frame mid-way with reset held low for three cycles.
    @(negedge clock);
    modo = 2'd3; start = 1'b1; pixel_in_valid = 1'b0; saida_pronta = 1'b1;
    @(negedge clock);
    start = 1'b0; pixel_in_valid = 1'b1; pixel_in = 8'd77;
    repeat (30) @(negedge clock);
    #1;
    check("abort_pre_pronto", pixel_pronto, 1);
    reset = 1'b0;
    #1;
    check("abort_pronto", pixel_pronto, 0);
    check("abort_ocupado", ocupado, 0);
    check("abort_ler", ler_pixel, 0);
    repeat (3) @(negedge clock);
    #1;
    check("abort_fim", frame_fim, 0);
    check("abort_out", pixel_out, 0);
    pixel_in_valid = 1'b0;
    reset = 1'b1;

    // Ramp passthrough after the abort, with a stall at output 10.
    for (int i = 0; i < TOTAL; i++) begin img[i] = 8'(i * 5); exp_v[i] = 8'(i * 5); end
    run_frame("ramp_pass", 2'd3, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/kernel_conv3x3.md
Name: kernel_conv3x3

Overview:
Streaming 3x3 neighbourhood filter for raster-order grayscale frames. It generalises the fixed 8-bit Sobel kernel with parametrised pixel width, a run-time filter mode and ready/valid handshakes with downstream backpressure. It sits between the frame-buffer reader and the output writer in the pipeline. Each `start` processes exactly one WIDTH x HEIGHT frame.

Parameters:
- WIDTH, 160, pixels per line (>= 4).
- HEIGHT, 120, lines per frame (>= 3).
- DATA_WIDTH, 8, bits per pixel, input and output.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset.
- start  in  1  one-cycle pulse that begins a frame. Ignored unless in IDLE.
- modo  in  2  filter select, sampled on the accepted `start`:
  - 0 = Sobel
  - 1 = Gaussian
  - 2 = Laplacian
  - 3 = passthrough
- pixel_in  in  DATA_WIDTH  input pixel, raster order.
- pixel_in_valid  in  1  `pixel_in` is valid.
- ler_pixel  out  1  input ready. A transfer occurs when `ler_pixel` && `pixel_in_valid`.
- pixel_out  out  DATA_WIDTH  filtered pixel, registered.
- pixel_pronto  out  1  `pixel_out` is valid. Held until accepted.
- saida_pronta  in  1  downstream ready. Output transfer occurs when `pixel_pronto` && `saida_pronta`.
- ocupado  out  1  high in every state except IDLE.
- frame_fim  out  1  one-cycle pulse after the last output transfer.

Behaviour:
- Reset (asynchronous): all outputs are 0. State = IDLE. All counters and pointers are 0. Line-buffer contents are don't-care. Reset mid-frame aborts immediately, with no partial-frame pulse.
- States and transitions:
  - IDLE -> FILL on `start`; latch `modo`.
  - FILL -> RUN after W+1 shifts.
  - RUN -> FLUSH when all TOTAL = WIDTH*HEIGHT inputs have been accepted.
  - FLUSH -> DONE when the output count reaches TOTAL.
  - DONE: pulse `frame_fim` for 1 cycle, then -> IDLE.
- Line buffers and window: two WIDTH-deep line buffers plus a 3x3 shift window, with a circular column pointer that wraps at WIDTH-1.
- Shift rule: each shift pushes one new column.
  - New column bottom = the accepted pixel in FILL/RUN, or 0 in FLUSH.
  - Middle and top come from the line buffers, which rotate as in the existing Sobel kernel.
- Shift enable:
  - Source available: an input transfer in FILL/RUN, or unconditionally in FLUSH.
  - AND one of:
    - the shift produces no output (shift count <= W+1), or
    - the output register is free (!`pixel_pronto` || `saida_pronta`).
- `ler_pixel` = state in {FILL, RUN} && inputs_accepted < TOTAL && output register free or not yet producing.
  - `ler_pixel` never depends on `pixel_in_valid`.
- Alignment: window centre after shift j (1-indexed) is input pixel j-W-2.
  - Shift k+W+2 computes output k and registers it.
  - `pixel_pronto` rises on the next clock edge.
  - Exactly TOTAL+W+1 shifts occur per frame.
- Output coordinates: (row, col) counters advance on each output load, in raster order.
- Border outputs (row 0, row HEIGHT-1, col 0, col WIDTH-1):
  - 0 in modes 0-2.
  - The centre pixel in mode 3.
- Arithmetic: signed, at least DATA_WIDTH+5 bits. MAX = 2^DATA_WIDTH-1.
  - Mode 0: |Gx|+|Gy| with the standard Sobel kernels, saturated to MAX.
  - Mode 1: (1 2 1; 2 4 2; 1 2 1) sum >> 4, truncating.
  - Mode 2: |4c - n - s - e - w|, saturated to MAX.
  - Mode 3: centre pixel.
- Backpressure: while `pixel_pronto`=1 and `saida_pronta`=0:
  - `pixel_out` and `pixel_pronto` hold.
  - No shift occurs.
  - `ler_pixel`=0 once the pipeline is producing.
- Simultaneous output accept and new load: back-to-back throughput of 1 pixel/cycle is sustained.
- `start` while `ocupado`=1 is ignored. `modo` changes mid-frame have no effect.

Test Plan:
- Reset behaviour: assert reset low for 3 cycles mid-frame, then release -> `pixel_pronto`=0, `ocupado`=0, `ler_pixel`=0. A following `start` yields a correct full frame.
- Flat input: WIDTH=8, HEIGHT=6, all pixels 100, `valid` and `saida_pronta` tied high.
  - Mode 0 -> 48 outputs, all 0.
  - Mode 1 -> interior 100, border 0.
  - Exactly one `frame_fim`, 1 cycle after output 47.
  - First `pixel_pronto` one cycle after input 9 is accepted.
- Vertical step, mode 0: columns 0-3 = 0, columns 4-7 = 200 -> interior columns 3 and 4 = 255 (800 saturated), all others 0.
- Impulse:
  - Mode 2, 50 at (2,3), all else 0 -> (2,3)=200; (1,3), (3,3), (2,2), (2,4)=50; all others 0.
  - Mode 1, impulse 160 -> centre 40, orthogonal neighbours 20, diagonals 10.
- Backpressure: hold `saida_pronta`=0 for 20 cycles at output 10, then toggle it pseudo-randomly -> `pixel_out` stable while stalled, no input accepted during the stall, output sequence identical to the unstalled run.
- Input bubbles: `pixel_in_valid` low on every third cycle -> identical outputs, no extra or missing pixels, TOTAL outputs, `start` pulses during the frame ignored.
